// File: rtl/bexkat2_busarb_pkg.sv
// Shared bexkat definitions used by the instruction/data bus arbiter.
package bexkat1Def;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_INS = 2'b01,
    GNT_DAT = 2'b10
  } busarb_state_t;

  typedef logic [1:0] busarb_owner_t;

  localparam busarb_owner_t OWN_NONE = 2'b00;
  localparam busarb_owner_t OWN_INS  = 2'b01;
  localparam busarb_owner_t OWN_DAT  = 2'b10;

endpackage

// File: rtl/bexkat2_busarb_if.sv
// Pipelined Wishbone bus. Data fields are named dat_m (master to slave)
// and dat_s (slave to master), so no modport expressions are needed.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;

  // Handshake: a strobe is accepted in any cycle where stb=1 and stall=0;
  // each accepted strobe is answered by exactly one ack, in order.
  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, stall
  );
endinterface

// File: rtl/bexkat2_busarb.sv
// Two-port Wishbone arbiter (instruction/data) onto one pipelined memory bus.
// Define BUSARB_RR_EN for round-robin arbitration; otherwise fixed priority.
module bexkat2_busarb
  import bexkat1Def::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter bit DAT_PRIORITY    = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  if_wb.slave           ins_bus,
  if_wb.slave           dat_bus,
  if_wb.master          mem_bus,
  output busarb_owner_t owner
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  busarb_state_t state, state_nxt;
  logic [3:0]    outst, outst_nxt;
  logic          blk, blk_nxt;
  logic          pick_dat, own_cyc, full, ack_ok;
  logic          accept, ack_cnt, violation, grant_start;

`ifdef BUSARB_RR_EN
  logic last_dat;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                last_dat <= 1'b0;
    else if (state == GNT_INS) last_dat <= 1'b0;
    else if (state == GNT_DAT) last_dat <= 1'b1;
  end

  assign pick_dat = dat_bus.cyc & (~ins_bus.cyc | ~last_dat);
`else
  assign pick_dat = dat_bus.cyc & (~ins_bus.cyc | DAT_PRIORITY);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      outst <= 4'd0;
      blk   <= 1'b0;
    end else begin
      state <= state_nxt;
      outst <= outst_nxt;
      blk   <= blk_nxt;
    end
  end

  // Grants are non-preemptive: only the owner dropping cyc moves the grant.
  always_comb begin
    state_nxt = state;
    own_cyc   = 1'b0;
    unique case (state)
      IDLE:
        if (ins_bus.cyc | dat_bus.cyc) state_nxt = pick_dat ? GNT_DAT : GNT_INS;
      GNT_INS: begin
        own_cyc = ins_bus.cyc;
        if (!ins_bus.cyc) state_nxt = dat_bus.cyc ? GNT_DAT : IDLE;
      end
      GNT_DAT: begin
        own_cyc = dat_bus.cyc;
        if (!dat_bus.cyc) state_nxt = ins_bus.cyc ? GNT_INS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign owner = (state == GNT_INS) ? OWN_INS :
                 (state == GNT_DAT) ? OWN_DAT : OWN_NONE;

  assign full   = (outst == MAX_OUT);
  assign ack_ok = (outst != 4'd0) && !blk;

  always_comb begin
    mem_bus.cyc   = 1'b0;
    mem_bus.stb   = 1'b0;
    mem_bus.we    = 1'b0;
    mem_bus.adr   = '0;
    mem_bus.sel   = '0;
    mem_bus.dat_m = '0;
    ins_bus.stall = 1'b1;
    ins_bus.ack   = 1'b0;
    ins_bus.dat_s = '0;
    dat_bus.stall = 1'b1;
    dat_bus.ack   = 1'b0;
    dat_bus.dat_s = '0;
    unique case (state)
      GNT_INS: begin
        mem_bus.cyc   = ins_bus.cyc;
        mem_bus.stb   = ins_bus.cyc & ins_bus.stb & ~full;
        mem_bus.we    = ins_bus.we;
        mem_bus.adr   = ins_bus.adr;
        mem_bus.sel   = ins_bus.sel;
        mem_bus.dat_m = ins_bus.dat_m;
        ins_bus.stall = mem_bus.stall | full;
        ins_bus.ack   = mem_bus.ack & ack_ok;
        ins_bus.dat_s = mem_bus.dat_s;
      end
      GNT_DAT: begin
        mem_bus.cyc   = dat_bus.cyc;
        mem_bus.stb   = dat_bus.cyc & dat_bus.stb & ~full;
        mem_bus.we    = dat_bus.we;
        mem_bus.adr   = dat_bus.adr;
        mem_bus.sel   = dat_bus.sel;
        mem_bus.dat_m = dat_bus.dat_m;
        dat_bus.stall = mem_bus.stall | full;
        dat_bus.ack   = mem_bus.ack & ack_ok;
        dat_bus.dat_s = mem_bus.dat_s;
      end
      default: ;
    endcase
  end

  // Acks with nothing outstanding (stale or after an abandoned cycle) are dropped.
  assign accept      = mem_bus.stb & ~mem_bus.stall;
  assign ack_cnt     = mem_bus.ack & ack_ok & (state != IDLE);
  assign violation   = (state != IDLE) & ~own_cyc & (outst != 4'd0);
  assign grant_start = (state_nxt != IDLE) & (state_nxt != state);

  always_comb begin
    outst_nxt = outst;
    if (violation)               outst_nxt = 4'd0;
    else if (accept && !ack_cnt) outst_nxt = outst + 4'd1;
    else if (!accept && ack_cnt) outst_nxt = outst - 4'd1;
  end

  assign blk_nxt = grant_start ? 1'b0 : (violation ? 1'b1 : blk);

endmodule

// File: tb/tb_bexkat2_busarb.sv
// Directed bench for bexkat2_busarb: reset, grant/hand-off, throttling,
// dropped cycles with outstanding acks and mid-transaction reset.
module tb_bexkat2_busarb;
  import bexkat1Def::*;

  logic          clk;
  logic          rst_n;
  busarb_owner_t owner;

  if_wb ins_if();
  if_wb dat_if();
  if_wb mem_if();

  bexkat2_busarb #(
    .MAX_OUTSTANDING(4),
    .DAT_PRIORITY(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .ins_bus(ins_if),
    .dat_bus(dat_if),
    .mem_bus(mem_if),
    .owner(owner)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // driver tasks
  task automatic ins_drive(input logic cyc, input logic stb, input logic [31:0] adr);
    ins_if.cyc = cyc; ins_if.stb = stb; ins_if.adr = adr;
    ins_if.we = 1'b0; ins_if.sel = 4'hf; ins_if.dat_m = 32'h0;
  endtask

  task automatic dat_drive(input logic cyc, input logic stb, input logic [31:0] adr);
    dat_if.cyc = cyc; dat_if.stb = stb; dat_if.adr = adr;
    dat_if.we = 1'b0; dat_if.sel = 4'hf; dat_if.dat_m = 32'h0;
  endtask

  task automatic mem_drive(input logic ack, input logic [31:0] dat);
    mem_if.ack = ack; mem_if.dat_s = dat; mem_if.stall = 1'b0;
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] adr);
    return {adr[15:0], ~adr[15:0]};
  endfunction

  initial begin
    int s;
    int max_pend;
    int n_ack;
    logic st5, st6, st7;

    rst_n = 1'b0;
    ins_drive(1'b1, 1'b1, 32'h1000);
    dat_drive(1'b1, 1'b1, 32'h2000);
    mem_drive(1'b0, 32'h0);

    // reset with both ports requesting
    repeat (2) @(posedge clk);
    sample();
    chk("rst_owner", owner, OWN_NONE);
    chk("rst_mem_cyc", mem_if.cyc, 1'b0);
    chk("rst_mem_adr", mem_if.adr, 32'h0);
    chk("rst_ins_stall", ins_if.stall, 1'b1);
    chk("rst_dat_stall", dat_if.stall, 1'b1);
    chk("rst_ins_ack", ins_if.ack, 1'b0);

    next_cyc();
    rst_n = 1'b1;
    sample();
    chk("rel_idle_owner", owner, OWN_NONE);
    chk("rel_idle_dat_stall", dat_if.stall, 1'b1);
    next_cyc();
    sample();
    chk("tie_owner_dat", owner, OWN_DAT);
    chk("tie_mem_cyc", mem_if.cyc, 1'b1);
    chk("tie_mem_adr", mem_if.adr, 32'h2000);
    chk("tie_dat_stall", dat_if.stall, 1'b0);
    chk("tie_ins_stall", ins_if.stall, 1'b1);

    next_cyc();
    dat_drive(1'b1, 1'b0, 32'h2000);
    mem_drive(1'b1, 32'h1111_2222);
    sample();
    chk("dat_ack", dat_if.ack, 1'b1);
    chk("dat_rdata", dat_if.dat_s, 32'h1111_2222);
    chk("ins_no_ack", ins_if.ack, 1'b0);
    chk("ins_no_data", ins_if.dat_s, 32'h0);

    next_cyc();
    mem_drive(1'b0, 32'h0);
    dat_drive(1'b0, 1'b0, 32'h0);
    sample();
    chk("drop_owner_dat", owner, OWN_DAT);
    chk("drop_mem_cyc", mem_if.cyc, 1'b0);
    next_cyc();
    sample();
    chk("handoff_owner_ins", owner, OWN_INS);
    chk("handoff_mem_adr", mem_if.adr, 32'h1000);

    next_cyc();
    ins_drive(1'b1, 1'b0, 32'h1000);
    mem_drive(1'b1, 32'h3333_4444);
    sample();
    chk("ins_ack", ins_if.ack, 1'b1);
    chk("ins_rdata", ins_if.dat_s, 32'h3333_4444);
    next_cyc();
    mem_drive(1'b0, 32'h0);
    ins_drive(1'b0, 1'b0, 32'h0);
    next_cyc();
    sample();
    chk("back_idle", owner, OWN_NONE);

    // single instruction read
    next_cyc();
    ins_drive(1'b1, 1'b1, 32'h7000_0000);
    sample();
    chk("rd_req_owner", owner, OWN_NONE);
    chk("rd_req_stall", ins_if.stall, 1'b1);
    next_cyc();
    sample();
    chk("rd_owner", owner, OWN_INS);
    chk("rd_mem_stb", mem_if.stb, 1'b1);
    chk("rd_mem_adr", mem_if.adr, 32'h7000_0000);
    next_cyc();
    ins_drive(1'b1, 1'b0, 32'h7000_0000);
    mem_drive(1'b1, 32'hDEAD_BEEF);
    sample();
    chk("rd_ack", ins_if.ack, 1'b1);
    chk("rd_data", ins_if.dat_s, 32'hDEAD_BEEF);
    next_cyc();
    mem_drive(1'b0, 32'h0);
    ins_drive(1'b0, 1'b0, 32'h0);
    next_cyc();

    // four ties in IDLE
    for (int r = 0; r < 4; r++) begin
      ins_drive(1'b1, 1'b0, 32'h0);
      dat_drive(1'b1, 1'b0, 32'h0);
      next_cyc();
      sample();
`ifdef BUSARB_RR_EN
      chk($sformatf("rr_tie%0d", r), owner, (r % 2 == 0) ? OWN_DAT : OWN_INS);
`else
      chk($sformatf("fixed_tie%0d", r), owner, OWN_DAT);
`endif
      next_cyc();
      ins_drive(1'b0, 1'b0, 32'h0);
      dat_drive(1'b0, 1'b0, 32'h0);
      next_cyc();
    end

    // six pipelined strobes against a MAX_OUTSTANDING of 4
    for (int k = 0; k < 6; k++) exp_q.push_back(mem_data(32'h100 + 32'(4 * k)));
    s = 0; max_pend = 0; n_ack = 0;
    st5 = 1'b0; st6 = 1'b0; st7 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ins_drive(1'b1, (s < 6), 32'h100 + 32'(4 * s));
      if (k >= 6 && pend.size() > 0) mem_drive(1'b1, mem_data(pend[0]));
      else mem_drive(1'b0, 32'h0);
      sample();
      if (k == 5) st5 = ins_if.stall;
      if (k == 6) st6 = ins_if.stall;
      if (k == 7) st7 = ins_if.stall;
      if (ins_if.ack) begin
        n_ack++;
        if (exp_q.size() > 0) chk("thr_data", ins_if.dat_s, exp_q.pop_front());
        else chk("thr_extra_ack", ins_if.ack, 1'b0);
      end
      if (ins_if.stb && !ins_if.stall) s++;
      if (mem_if.stb && !mem_if.stall) pend.push_back(mem_if.adr);
      if (mem_if.ack && pend.size() > 0) void'(pend.pop_front());
      if (pend.size() > max_pend) max_pend = pend.size();
      next_cyc();
    end
    chk("thr_stall_5th", st5, 1'b1);
    chk("thr_stall_ack_cycle", st6, 1'b1);
    chk("thr_stall_lifted", st7, 1'b0);
    chk("thr_max_outst", max_pend, 4);
    chk("thr_ack_count", n_ack, 6);
    chk("thr_queue_empty", exp_q.size(), 0);
    chk("thr_outst_end", dut.outst, 4'd0);
    ins_drive(1'b0, 1'b0, 32'h0);
    mem_drive(1'b0, 32'h0);
    next_cyc();

    // simultaneous accept and ack, then dat abandons two outstanding strobes
    dat_drive(1'b1, 1'b1, 32'h400);
    next_cyc();
    dat_drive(1'b1, 1'b1, 32'h404);
    next_cyc();
    dat_drive(1'b1, 1'b1, 32'h408);
    next_cyc();
    dat_drive(1'b1, 1'b1, 32'h40C);
    mem_drive(1'b1, 32'h0000_0400);
    sample();
    chk("sim_dat_ack", dat_if.ack, 1'b1);
    next_cyc();
    mem_drive(1'b0, 32'h0);
    dat_drive(1'b0, 1'b0, 32'h0);
    ins_drive(1'b1, 1'b0, 32'h0);
    sample();
    chk("sim_outst_2", dut.outst, 4'd2);
    chk("viol_owner_dat", owner, OWN_DAT);
    next_cyc();
    mem_drive(1'b1, 32'hBAD0_0001);
    sample();
    chk("viol_owner_ins", owner, OWN_INS);
    chk("viol_outst_clr", dut.outst, 4'd0);
    chk("viol_no_ack1", ins_if.ack, 1'b0);
    next_cyc();
    mem_drive(1'b1, 32'hBAD0_0002);
    sample();
    chk("viol_no_ack2", ins_if.ack, 1'b0);
    chk("viol_dat_no_ack", dat_if.ack, 1'b0);
    next_cyc();
    mem_drive(1'b0, 32'h0);
    ins_drive(1'b1, 1'b1, 32'h500);
    sample();
    chk("viol_no_underflow", dut.outst, 4'd0);
    next_cyc();
    ins_drive(1'b1, 1'b0, 32'h500);
    mem_drive(1'b1, 32'h5555_AAAA);
    sample();
    chk("restart_outst_1", dut.outst, 4'd1);
    chk("restart_ack", ins_if.ack, 1'b1);
    chk("restart_data", ins_if.dat_s, 32'h5555_AAAA);
    next_cyc();
    mem_drive(1'b0, 32'h0);
    ins_drive(1'b1, 1'b1, 32'h600);

    // reset in the middle of an ins transaction
    sample();
    chk("mid_mem_cyc", mem_if.cyc, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_owner", owner, OWN_NONE);
    chk("mid_rst_mem_cyc", mem_if.cyc, 1'b0);
    chk("mid_rst_ins_stall", ins_if.stall, 1'b1);
    mem_drive(1'b1, 32'hBAD0_0003);
    next_cyc();
    rst_n = 1'b1;
    sample();
    chk("mid_rel_idle", owner, OWN_NONE);
    next_cyc();
    sample();
    chk("mid_regrant", owner, OWN_INS);
    chk("mid_stale_ack", ins_if.ack, 1'b0);
    next_cyc();
    mem_drive(1'b0, 32'h0);
    ins_drive(1'b0, 1'b0, 32'h0);
    next_cyc();
    next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bexkat2_busarb.md
# bexkat2_busarb

Two-port Wishbone arbiter that shares one pipelined memory bus between the bexkat2 core's instruction and data buses. It sits between the CPU and the system interconnect: it grants one port at a time, forwards its cycle without added latency once granted, and tracks outstanding pipelined requests. A port keeps its grant until it drops `cyc`.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum accepted-but-unacknowledged strobes per grant, range 1..15.
- `DAT_PRIORITY`, default 1: in fixed-priority mode, 1 gives the data port priority and 0 gives the instruction port priority.

- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `ins_bus`  if_wb.slave  iface  connects to the core instruction master.
- `dat_bus`  if_wb.slave  iface  connects to the core data master.
- `mem_bus`  if_wb.master  iface  connects to the shared memory interconnect.
- `owner`  out  2  current grant: 00 none, 01 ins, 10 dat. For debug and verification.

## Operation
- State machine states:
  - IDLE: no grant.
  - GNT_INS: instruction port owns `mem_bus`.
  - GNT_DAT: data port owns `mem_bus`.
- IDLE:
  - If any port asserts `cyc`, grant the winner at the next edge.
  - Winner is selected by the arbitration rule (see Configuration).
- GNT_x, while owner `cyc` is 1:
  - Stay in GNT_x.
  - `mem_bus` `cyc`, `stb`, `we`, `adr`, `sel` and write data are driven combinationally from owner.
  - Owner `ack` and read data are driven combinationally from `mem_bus`.
- GNT_x, owner `cyc` is 0 in the current cycle:
  - Other port `cyc` is 1: go directly to GNT_other at the next edge.
  - Otherwise go to IDLE.
- Non-granted port:
  - `stall`=1, `ack`=0, read data=0.
  - Its `cyc` and `stb` are ignored.
- Outstanding counter `outst`, 4-bit:
  - Increment on `mem_bus` `stb` & !`stall`.
  - Decrement on `mem_bus` `ack`.
  - Increment and decrement in the same cycle leave it unchanged.
- Throttling: when `outst`==MAX_OUTSTANDING, force owner `stall`=1 and `mem_bus` `stb`=0.
  - An `ack` in that same cycle does not lift the stall until the next cycle.
- Owner drops `cyc` with `outst`>0 (protocol violation):
  - Clear `outst` to 0.
  - Block `ack` routing, so no `ack` reaches any port, until a new grant begins.
- `mem_bus` `ack` with `outst`==0 is dropped and does not underflow the counter.

## Timing
- Reset values:
  - State IDLE, `owner`=00, `outst`=0.
  - `mem_bus` `cyc`/`stb`/`we`=0, `adr`=0, `sel`=0, write data=0.
  - Both slave ports: `stall`=1, `ack`=0, data=0.
- Grant latency: request in IDLE at cycle N; `mem_bus` `cyc`/`stb` are visible in cycle N+1.
  - The requester sees `stall`=1 in cycle N and holds its `stb`, as required by Wishbone.
- Hand-off latency: owner drops `cyc` in cycle N; the other port owns the bus in cycle N+1.
  - No `mem_bus` `cyc` gap beyond that cycle.
- Data path: zero added latency once granted. All forwarding paths are combinational; only state, `owner` and `outst` are registered.
- Reset asserted mid-transaction aborts immediately to the reset values. In-flight `ack`s after reset are dropped.

## Configuration
- `BUSARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests in IDLE, or at hand-off, the port that did not own the bus most recently wins.
  - A 1-bit `last` register records the most recent owner; it resets to ins, so dat wins the first tie.
  - `DAT_PRIORITY` is ignored.
- `BUSARB_RR_EN` not defined: fixed priority per `DAT_PRIORITY`.
  - Grants are still non-preemptive.

## Structure
- Shared package `bexkat1Def` gets:
  - `busarb_state_t` enum: IDLE, GNT_INS, GNT_DAT.
  - `busarb_owner_t` 2-bit constants: OWN_NONE, OWN_INS, OWN_DAT.
- No sub-module required. The optional `bexkat2_busarb_cnt` holds the outstanding counter, saturate logic and the violation clear.
- Honour `NO_MODPORT_EXPRESSIONS` for the data fields (`dat_s`/`dat_m` vs `dat_i`/`dat_o`), as the core does.

## Test plan
- Reset with `rst_i`=0 while both ports request: `owner`=00, `mem_bus` `cyc`=0, both ports `stall`=1. Release reset: grant appears on the next edge.
- ins only, single read of addr 0x7000_0000, mem `ack` with data 0xDEADBEEF one cycle later: `owner`=01, ins gets `ack` and 0xDEADBEEF. Total 3 cycles from `cyc` to `ack`.
- Both request in IDLE:
  - Fixed priority, `DAT_PRIORITY`=1: dat granted first; ins granted the cycle after dat drops `cyc`.
  - `BUSARB_RR_EN`: four back-to-back ties alternate dat, ins, dat, ins.
- Owner issues 6 pipelined strobes with mem never stalling and acks delayed, `MAX_OUTSTANDING`=4: the 5th strobe sees `stall`=1 until the first `ack`. `outst` never exceeds 4; all 6 acks return in order.
- Simultaneous `stb` accept and `ack` at `outst`=2: `outst` stays 2.
- dat drops `cyc` with `outst`=2, then mem returns 2 acks while ins is granted: ins receives no spurious `ack`, and `outst` restarts from 0.
